// File: rtl/spi_sclk_engine.sv
// SPI master clock engine: divides PClk into SCLK and runs framed transfers with
// single-cycle sample/shift strobes for all four CPOL/CPHA modes.
module spi_sclk_engine #(
  parameter int PRESC_W   = 3,
  parameter int RATE_W    = 3,
  parameter int CNT_W     = 12,
  parameter int FRAME_MAX = 8,
  localparam int LEN_W    = $clog2(FRAME_MAX + 1)
) (
  input  logic               PClk,
  input  logic               PRESETn,
  input  logic [1:0]         spi_mode,
  input  logic               spiswai,
  input  logic               cpol,
  input  logic               cpha,
  input  logic [PRESC_W-1:0] sppr,
  input  logic [RATE_W-1:0]  spr,
  input  logic               start,
  input  logic [LEN_W-1:0]   frame_len,
  input  logic               abort,
  output logic               sclk,
  output logic               sample_stb,
  output logic               shift_stb,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   baud_rate_divisor
);

  localparam int EDGE_W = LEN_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               sclk_q, sclk_d;
  logic               sample_q, sample_d;
  logic               shift_q, shift_d;
  logic               done_q, done_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [EDGE_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [EDGE_W-1:0]  two_n_q, two_n_d;

  logic [CNT_W-1:0]   half_live;
  logic [LEN_W-1:0]   n_clamped;
  logic               active;

  // Half period is (sppr+1)*2^spr; shifting in two steps avoids wrapping spr+1.
  assign half_live         = (CNT_W'(sppr) + CNT_W'(1)) << spr;
  assign baud_rate_divisor = half_live << 1;

  assign n_clamped = (frame_len > LEN_W'(FRAME_MAX)) ? LEN_W'(FRAME_MAX) : frame_len;
  assign active    = (spi_mode == 2'b00) || ((spi_mode == 2'b01) && !spiswai);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    state_d    = state_q;
    sclk_d     = sclk_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    half_d     = half_q;
    hcnt_d     = hcnt_q;
    edge_cnt_d = edge_cnt_q;
    two_n_d    = two_n_q;
    sample_d   = 1'b0;
    shift_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = cpol;
        if (start && active && (frame_len != '0) && !abort) begin
          state_d    = ST_RUN;
          cpol_d     = cpol;
          cpha_d     = cpha;
          half_d     = half_live;
          two_n_d    = {n_clamped, 1'b0};
          hcnt_d     = '0;
          edge_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          sclk_d  = cpol_q;
        end else if (active) begin
          if (hcnt_q == half_q - 1'b1) begin
            hcnt_d = '0;
            if (edge_cnt_q != two_n_q) begin
              edge_cnt_d = edge_cnt_q + 1'b1;
              sclk_d     = ~sclk_q;
              // Odd edge numbers are leading edges; the final trailing edge drives no new bit.
              if (edge_cnt_d[0]) begin
                shift_d  = cpha_q;
                sample_d = !cpha_q;
              end else begin
                sample_d = cpha_q;
                shift_d  = !cpha_q && (edge_cnt_d != two_n_q);
              end
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              sclk_d  = cpol_q;
            end
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      sclk_q     <= 1'b0;
      sample_q   <= 1'b0;
      shift_q    <= 1'b0;
      done_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      half_q     <= '0;
      hcnt_q     <= '0;
      edge_cnt_q <= '0;
      two_n_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      sclk_q     <= sclk_d;
      sample_q   <= sample_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      half_q     <= half_d;
      hcnt_q     <= hcnt_d;
      edge_cnt_q <= edge_cnt_d;
      two_n_q    <= two_n_d;
    end
  end

  assign sclk       = sclk_q;
  assign sample_stb = sample_q;
  assign shift_stb  = shift_q;
  assign done       = done_q;
  assign busy       = (state_q == ST_RUN);

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Self-checking bench for spi_sclk_engine: frames are compared event-by-event against
// an edge-schedule model computed from divisor, frame length, mode and freeze window.
module tb_spi_sclk_engine;

  localparam int PRESC_W   = 3;
  localparam int RATE_W    = 3;
  localparam int CNT_W     = 12;
  localparam int FRAME_MAX = 8;
  localparam int LEN_W     = 4;
  localparam int NO_FREEZE = 1 << 30;

  logic               PClk;
  logic               PRESETn;
  logic [1:0]         spi_mode;
  logic               spiswai;
  logic               cpol;
  logic               cpha;
  logic [PRESC_W-1:0] sppr;
  logic [RATE_W-1:0]  spr;
  logic               start;
  logic [LEN_W-1:0]   frame_len;
  logic               abort;
  logic               sclk;
  logic               sample_stb;
  logic               shift_stb;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   baud_rate_divisor;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    logic [2:0] val;   // {sclk, sample_stb, shift_stb}
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  spi_sclk_engine #(
    .PRESC_W  (PRESC_W),
    .RATE_W   (RATE_W),
    .CNT_W    (CNT_W),
    .FRAME_MAX(FRAME_MAX)
  ) dut (
    .PClk             (PClk),
    .PRESETn          (PRESETn),
    .spi_mode         (spi_mode),
    .spiswai          (spiswai),
    .cpol             (cpol),
    .cpha             (cpha),
    .sppr             (sppr),
    .spr              (spr),
    .start            (start),
    .frame_len        (frame_len),
    .abort            (abort),
    .sclk             (sclk),
    .sample_stb       (sample_stb),
    .shift_stb        (shift_stb),
    .busy             (busy),
    .done             (done),
    .baud_rate_divisor(baud_rate_divisor)
  );

  initial PClk = 1'b0;
  always #5 PClk = ~PClk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Edge k occurs k*H active cycles after busy rises; a freeze window pushes later events out.
  task automatic model_frame(input int n, input int h, input bit cp, input bit ch,
                             input int fs, input int fl, output int done_cyc);
    ev_t e;
    bit  lead;
    exp_q.delete();
    for (int k = 1; k <= 2 * n; k++) begin
      lead  = (k % 2) == 1;
      e.cyc = (k * h > fs) ? k * h + fl : k * h;
      e.val = {cp ^ lead, ch ? !lead : lead, ch ? lead : (!lead && k != 2 * n)};
      exp_q.push_back(e);
    end
    done_cyc = ((2 * n + 1) * h > fs) ? (2 * n + 1) * h + fl : (2 * n + 1) * h;
  endtask

  // Returns at the negedge of the first busy cycle, with the live config scrambled.
  task automatic launch(input int sp, input int sr, input bit cp, input bit ch, input int len);
    @(negedge PClk);
    sppr = PRESC_W'(sp); spr = RATE_W'(sr); cpol = cp; cpha = ch;
    frame_len = LEN_W'(len); spi_mode = 2'b00; spiswai = 1'b0;
    @(negedge PClk);
    start = 1'b1;
    @(negedge PClk);
    start = 1'b0;
    sppr = PRESC_W'($urandom); spr = RATE_W'($urandom);
    cpol = 1'($urandom); cpha = 1'($urandom); frame_len = LEN_W'($urandom);
  endtask

  task automatic run_frame(input string name, input int sp, input int sr, input bit cp,
                           input bit ch, input int len, input int fs, input int fl,
                           input logic [1:0] fmode, input bit fswai);
    int   n, h, exp_done, busy_cnt, done_at, limit, i, mfs, mfl;
    logic prev;
    ev_t  e;
    bit   frozen;
    n      = (len > FRAME_MAX) ? FRAME_MAX : len;
    h      = (sp + 1) * (2 ** sr);
    frozen = (fs != NO_FREEZE) && (fmode != 2'b00) && !(fmode == 2'b01 && !fswai);
    mfs    = frozen ? fs : NO_FREEZE;
    mfl    = frozen ? fl : 0;
    model_frame(n, h, cp, ch, mfs, mfl, exp_done);
    launch(sp, sr, cp, ch, len);
    obs_q.delete();
    prev = cp; busy_cnt = 0; done_at = -1; limit = exp_done + fl + 20; i = 0;
    forever begin
      if (busy) busy_cnt++;
      if (sclk !== prev || sample_stb || shift_stb) begin
        e.cyc = i; e.val = {sclk, sample_stb, shift_stb};
        obs_q.push_back(e);
      end
      prev = sclk;
      if (done) done_at = i;
      if (!busy) break;
      if (i == fs) begin spi_mode = fmode; spiswai = fswai; end
      if (i == fs + fl) begin spi_mode = 2'b00; spiswai = 1'b0; end
      if (i >= limit) begin
        n_cmp++; n_err++;
        $display("FAIL %s timeout: busy still high after %0d cycles, required fall at %0d",
                 name, i, exp_done);
        break;
      end
      i++;
      @(negedge PClk);
    end
    spi_mode = 2'b00; spiswai = 1'b0;
    n_cmp++;
    if (busy_cnt !== exp_done) begin
      n_err++;
      $display("FAIL %s busy_len: got %0d required %0d", name, busy_cnt, exp_done);
    end
    n_cmp++;
    if (done_at !== exp_done) begin
      n_err++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, done_at, exp_done);
    end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL %s event_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
      n_cmp++;
      if (obs_q[j].cyc !== exp_q[j].cyc || obs_q[j].val !== exp_q[j].val) begin
        n_err++;
        $display("FAIL %s event%0d: got cyc=%0d {sclk,smp,shf}=%b required cyc=%0d %b",
                 name, j, obs_q[j].cyc, obs_q[j].val, exp_q[j].cyc, exp_q[j].val);
      end
    end
  endtask

  task automatic test_reset;
    int sp, sr;
    PRESETn = 1'b0; spi_mode = 2'b00; spiswai = 1'b0; cpol = 1'b0; cpha = 1'b0;
    sppr = '0; spr = '0; start = 1'b0; frame_len = '0; abort = 1'b0;
    repeat (3) @(negedge PClk);
    n_cmp++;
    if ({sclk, sample_stb, shift_stb, busy, done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 00000",
               {sclk, sample_stb, shift_stb, busy, done});
    end
    PRESETn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sp = $urandom_range(0, 7); sr = $urandom_range(0, 7);
      sppr = PRESC_W'(sp); spr = RATE_W'(sr);
      #1;
      n_cmp++;
      if (baud_rate_divisor !== CNT_W'((sp + 1) * (2 ** (sr + 1)))) begin
        n_err++;
        $display("FAIL divisor sppr=%0d spr=%0d: got %0d required %0d", sp, sr,
                 baud_rate_divisor, (sp + 1) * (2 ** (sr + 1)));
      end
    end
    @(negedge PClk);
    cpol = 1'b1;
    repeat (2) @(negedge PClk);
    n_cmp++;
    if ({sclk, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL idle_tracks_cpol: got {sclk,busy}=%b required 10", {sclk, busy});
    end
  endtask

  task automatic test_basic;
    run_frame("mode0_h1_n8", 0, 0, 1'b0, 1'b0, 8, NO_FREEZE, 0, 2'b00, 1'b0);
    run_frame("mode3_h6_n4", 2, 1, 1'b1, 1'b1, 4, NO_FREEZE, 0, 2'b00, 1'b0);
    run_frame("clamp_len15", 0, 1, 1'b0, 1'b1, 15, NO_FREEZE, 0, 2'b00, 1'b0);
  endtask

  task automatic test_freeze;
    run_frame("wait_swai", 1, 0, 1'b0, 1'b0, 8, 10, 10, 2'b01, 1'b1);
    run_frame("stop_mode", 0, 1, 1'b1, 1'b0, 3, 7, 5, 2'b10, 1'b0);
    run_frame("wait_noswai", 0, 1, 1'b0, 1'b1, 3, 5, 6, 2'b01, 1'b0);
  endtask

  task automatic test_abort;
    int   toggles, h;
    logic prev;
    bit   cp, ch, hit;
    cp = 1'($urandom); ch = 1'($urandom); h = 2;
    launch(1, 0, cp, ch, 8);
    prev = cp; toggles = 0; hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sclk !== prev) toggles++;
      prev = sclk;
      if (toggles == 3) begin hit = 1'b1; break; end
      @(negedge PClk);
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL abort_reach_edge3: got %0d toggles required 3", toggles);
    end
    abort = 1'b1;
    @(negedge PClk);
    abort = 1'b0;
    n_cmp++;
    if ({busy, sclk, sample_stb, shift_stb, done} !== {1'b0, cp, 3'b000}) begin
      n_err++;
      $display("FAIL abort_next_cycle: got %b required %b",
               {busy, sclk, sample_stb, shift_stb, done}, {1'b0, cp, 3'b000});
    end
    for (int i = 0; i < 4 * h; i++) begin
      @(negedge PClk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_err++;
        $display("FAIL abort_quiet cyc%0d: got {busy,done}=%b required 00", i, {busy, done});
      end
    end
    frame_len = 4'd3; spi_mode = 2'b00;
    start = 1'b1; abort = 1'b1;
    @(negedge PClk);
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_blocks_start: got busy=%b required 0", busy);
    end
    run_frame("after_abort", 0, 0, cp, ch, 8, NO_FREEZE, 0, 2'b00, 1'b0);
  endtask

  task automatic test_back_to_back;
    int   rises[$];
    int   dones[$];
    logic prev_busy;
    @(negedge PClk);
    sppr = 3'd1; spr = 3'd0; frame_len = 4'd2; cpol = 1'($urandom); cpha = 1'($urandom);
    @(negedge PClk);
    start = 1'b1; prev_busy = 1'b0;
    for (int i = 0; i < 60 && dones.size() < 2; i++) begin
      @(negedge PClk);
      if (busy && !prev_busy) rises.push_back(i);
      if (done) dones.push_back(i);
      prev_busy = busy;
    end
    start = 1'b0; abort = 1'b1;
    @(negedge PClk);
    abort = 1'b0;
    n_cmp++;
    if (rises.size() < 2 || dones.size() < 2) begin
      n_err++;
      $display("FAIL b2b_events: got %0d rises %0d dones required 2 and 2",
               rises.size(), dones.size());
    end else begin
      n_cmp += 3;
      if (dones[0] - rises[0] !== 10) begin
        n_err++;
        $display("FAIL b2b_len1: got %0d required 10", dones[0] - rises[0]);
      end
      if (rises[1] - dones[0] !== 1) begin
        n_err++;
        $display("FAIL b2b_gap: got %0d required 1", rises[1] - dones[0]);
      end
      if (dones[1] - rises[1] !== 10) begin
        n_err++;
        $display("FAIL b2b_len2: got %0d required 10", dones[1] - rises[1]);
      end
    end
    @(negedge PClk);
    frame_len = '0; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge PClk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_err++;
        $display("FAIL len0_ignored cyc%0d: got {busy,done}=%b required 00", i, {busy, done});
      end
    end
    start = 1'b0;
  endtask

  task automatic test_slow_and_reset;
    @(negedge PClk);
    sppr = 3'd7; spr = 3'd7;
    #1;
    n_cmp++;
    if (baud_rate_divisor !== 12'd2048) begin
      n_err++;
      $display("FAIL divisor_max: got %0d required 2048", baud_rate_divisor);
    end
    launch(7, 7, 1'b0, 1'($urandom), 8);
    repeat (1500) @(negedge PClk);
    n_cmp++;
    if ({busy, sclk} !== 2'b11) begin
      n_err++;
      $display("FAIL slow_first_edge: got {busy,sclk}=%b required 11", {busy, sclk});
    end
    PRESETn = 1'b0;
    #1;
    n_cmp++;
    if ({sclk, sample_stb, shift_stb, busy, done} !== 5'b0) begin
      n_err++;
      $display("FAIL async_reset: got %b required 00000",
               {sclk, sample_stb, shift_stb, busy, done});
    end
    @(negedge PClk);
    PRESETn = 1'b1; cpol = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PClk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_err++;
        $display("FAIL post_reset cyc%0d: got {busy,done}=%b required 00", i, {busy, done});
      end
    end
  endtask

  task automatic test_random;
    int sp, sr, len, n, h, fs, fl;
    for (int k = 0; k < 10; k++) begin
      sp = $urandom_range(0, 3); sr = $urandom_range(0, 2); len = $urandom_range(1, 11);
      n = (len > FRAME_MAX) ? FRAME_MAX : len;
      h = (sp + 1) * (2 ** sr);
      if ($urandom_range(0, 1) == 1) begin
        fs = $urandom_range(1, (2 * n + 1) * h - 1);
        fl = $urandom_range(1, 12);
      end else begin
        fs = NO_FREEZE; fl = 0;
      end
      run_frame($sformatf("rand%0d", k), sp, sr, 1'($urandom), 1'($urandom), len, fs, fl,
                2'($urandom_range(1, 3)), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_freeze();
    test_abort();
    test_back_to_back();
    test_random();
    test_slow_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
